// File: rtl/acc_sequencer.sv
// acc_sequencer: three-phase accumulator sequencer driving an external adder/subtractor
module acc_sequencer (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
    input  logic [1:0] Op,
    input  logic [3:0] D,
    input  logic [3:0] S,
    input  logic       Cout,
    input  logic       OVR,
    output logic       AddSub,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] ACC,
    output logic [3:0] Flags,
    output logic       Sticky,
    output logic       Busy,
    output logic       Done
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SUB, OP_CLR} op_t;

    state_t     state, state_nx;
    op_t        op_r;
    logic [3:0] br;

    assign A      = ACC;
    assign B      = br;
    assign Busy   = (state != IDLE);
    assign Done   = (state == WB);
    assign AddSub = (state == EXEC) && (op_r == OP_SUB);

    // state register; reset aborts any operation in flight
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) state <= IDLE;
        else         state <= state_nx;

    // next state: EXEC and WB are fixed single cycles, Start only matters in IDLE
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = Start ? EXEC : IDLE;
            EXEC:    state_nx = WB;
            default: state_nx = IDLE;
        endcase
    end

    // operand capture in IDLE, result commit at the EXEC->WB edge once the adder has settled
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            op_r   <= OP_LOAD;
            br     <= '0;
            ACC    <= '0;
            Flags  <= '0;
            Sticky <= 1'b0;
        end else begin
            if (state == IDLE && Start) begin
                op_r <= op_t'(Op);
                br   <= D;
            end
            if (state == EXEC)
                case (op_r)
                    OP_LOAD: begin
                        ACC        <= br;
                        Flags[3:2] <= {br == 4'd0, br[3]};
                    end
                    OP_CLR: begin
                        ACC    <= '0;
                        Flags  <= 4'b1000;
                        Sticky <= 1'b0;
                    end
                    default: begin
                        ACC    <= S;
                        Flags  <= {S == 4'd0, S[3], Cout, OVR};
                        Sticky <= Sticky | OVR;
                    end
                endcase
        end
endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: randomized scoreboard bench for acc_sequencer with a behavioural adder
module tb_acc_sequencer;
    typedef struct packed {
        logic [3:0] acc;
        logic [3:0] flags;
        logic       sticky;
    } res_t;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Start = 1'b0;
    logic [1:0] Op = 2'd0;
    logic [3:0] D = 4'd0;
    logic [3:0] S;
    logic       Cout, OVR;
    logic       AddSub, Busy, Done, Sticky;
    logic [3:0] A, B, ACC, Flags;
    logic [4:0] sum;

    int   total = 0;
    int   bad = 0;
    res_t q[$];
    res_t m;
    logic [3:0] m_br;
    logic [1:0] m_op;
    int   ph;

    acc_sequencer dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Op(Op), .D(D),
        .S(S), .Cout(Cout), .OVR(OVR), .AddSub(AddSub), .A(A), .B(B),
        .ACC(ACC), .Flags(Flags), .Sticky(Sticky), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    // downstream ripple adder/subtractor
    assign sum  = AddSub ? ({1'b0, A} + {1'b0, ~B} + 5'd1) : ({1'b0, A} + {1'b0, B});
    assign S    = sum[3:0];
    assign Cout = sum[4];
    assign OVR  = (A[3] == (B[3] ^ AddSub)) && (S[3] != A[3]);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sv4(input logic [3:0] x);
        return x >= 8 ? int'(x) - 16 : int'(x);
    endfunction

    function automatic res_t model(input logic [1:0] op, input logic [3:0] b, input res_t cur);
        res_t r;
        int   u, sg;
        r = cur;
        if (op == 2'd0) begin
            r.acc      = b;
            r.flags[3] = (b == 0);
            r.flags[2] = b[3];
        end else if (op == 2'd3) begin
            r.acc    = 4'd0;
            r.flags  = 4'b1000;
            r.sticky = 1'b0;
        end else begin
            u  = (op == 2'd1) ? int'(cur.acc) + int'(b) : int'(cur.acc) - int'(b);
            sg = (op == 2'd1) ? sv4(cur.acc) + sv4(b) : sv4(cur.acc) - sv4(b);
            r.acc    = 4'(u & 15);
            r.flags  = {u % 16 == 0, r.acc[3], (op == 2'd1) ? u > 15 : u >= 0, sg > 7 || sg < -8};
            r.sticky = cur.sticky | (sg > 7 || sg < -8);
        end
        return r;
    endfunction

    task automatic check_outputs();
        chk("busy", Busy, ph != 0);
        chk("done", Done, ph == 2);
        chk("addsub", AddSub, ph == 1 && m_op == 2'd2);
        chk("acc", ACC, m.acc);
        chk("a_eq_acc", A, m.acc);
        chk("b_eq_br", B, m_br);
        chk("flags", Flags, m.flags);
        chk("sticky", Sticky, m.sticky);
    endtask

    // drive one cycle of inputs, advance the reference model across the edge, check at negedge
    task automatic step(input logic st, input logic [1:0] op, input logic [3:0] d);
        res_t r;
        Start = st;
        Op    = op;
        D     = d;
        @(posedge Clock);
        if (ph == 0) begin
            if (st) begin
                m_op = op;
                m_br = d;
                ph   = 1;
            end
        end else if (ph == 1) begin
            r = model(m_op, m_br, m);
            m = r;
            q.push_back(r);
            ph = 2;
        end else ph = 0;
        @(negedge Clock);
        check_outputs();
    endtask

    task automatic run_op(input logic [1:0] op, input logic [3:0] d);
        step(1'b1, op, d);
        step(1'($urandom), 2'($urandom), 4'($urandom));
        step(1'($urandom), 2'($urandom), 4'($urandom));
    endtask

    task automatic do_reset();
        #2;
        Resetn = 1'b0;
        #1;
        ph   = 0;
        m    = '0;
        m_br = 4'd0;
        m_op = 2'd0;
        q.delete();
        check_outputs();
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    // scoreboard monitor: every Done pulse must match the oldest committed result
    always @(negedge Clock) begin
        if (Done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got Done=1 required no pending result at %0t", $time);
            end else begin
                res_t e;
                e = q.pop_front();
                chk("sb_acc", ACC, e.acc);
                chk("sb_flags", Flags, e.flags);
                chk("sb_sticky", Sticky, e.sticky);
            end
        end
    end

    initial begin
        m    = '0;
        m_br = 4'd0;
        m_op = 2'd0;
        ph   = 0;
        @(negedge Clock);
        do_reset();
        run_op(2'd0, 4'b0101);
        step(1'b0, 2'd0, 4'd0);
        chk("load5_acc", ACC, 5);
        chk("load5_flags", Flags, 0);
        run_op(2'd0, 4'b0111);
        run_op(2'd1, 4'b0001);
        chk("add_ovf_acc", ACC, 8);
        chk("add_ovf_flags", Flags, 4'b0101);
        chk("add_ovf_sticky", Sticky, 1);
        run_op(2'd0, 4'b0011);
        run_op(2'd2, 4'b0011);
        chk("sub_zero_acc", ACC, 0);
        chk("sub_zero_flags", Flags, 4'b1010);
        run_op(2'd2, 4'b0001);
        chk("sub_borrow_acc", ACC, 4'hf);
        chk("sub_borrow_flags", Flags, 4'b0100);
        chk("sub_borrow_sticky", Sticky, 1);
        run_op(2'd3, 4'd9);
        chk("clr_flags", Flags, 4'b1000);
        chk("clr_sticky", Sticky, 0);
        for (int i = 0; i < 9; i++) step(1'b1, 2'd1, 4'd1);
        chk("held_start_acc", ACC, 3);
        run_op(2'd0, 4'b0101);
        step(1'b1, 2'd1, 4'b0010);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 2'd1, 4'd2);
        chk("abort_acc", ACC, 0);
        chk("abort_flags", Flags, 0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 50) == 0) do_reset();
            step($urandom_range(0, 9) < 7, 2'($urandom), 4'($urandom));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 4'd0);
        chk("queue_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end
endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 Clock  in  1  sole clock; all state updates on rising edge.
REQ-002 Resetn  in  1  asynchronous, active-low reset.
REQ-003 Start  in  1  operation request; sampled only in IDLE.
REQ-004 Op  in  2  operation code: 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
REQ-005 D  in  4  operand.
REQ-006 S  in  4  sum/difference returned by the downstream ripple adder/subtractor.
REQ-007 Cout  in  1  carry-out returned by the adder/subtractor.
REQ-008 OVR  in  1  two's-complement overflow returned by the adder/subtractor.
REQ-009 AddSub  out  1  add/subtract select to the adder/subtractor (0 add, 1 subtract).
REQ-010 A  out  4  adder operand A; always equals ACC.
REQ-011 B  out  4  adder operand B; always equals the latched operand register BR.
REQ-012 ACC  out  4  accumulator.
REQ-013 Flags  out  4  {Z,N,C,V} status register.
REQ-014 Sticky  out  1  sticky overflow; set by any ADD/SUB with OVR=1.
REQ-015 Busy  out  1  high while an operation is in progress.
REQ-016 Done  out  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC and WB, encoded in registers.
REQ-018 In IDLE with Start=1 at edge k: latch Op into OpR and D into BR, go to EXEC.
REQ-019 In IDLE with Start=0: remain in IDLE; BR and OpR hold.
REQ-020 EXEC SHALL last exactly one cycle so the adder settles; at edge k+1 ACC, Flags and Sticky update per REQ-024..027, go to WB.
REQ-021 WB SHALL last exactly one cycle; at edge k+2 go to IDLE unconditionally.
REQ-022 Busy = (state != IDLE); Done = (state == WB); both decoded from registered state, glitch-free.
REQ-023 AddSub = 1 only when state == EXEC and OpR == SUB; otherwise 0.
REQ-024 ADD/SUB: ACC <= S; Z <= (S==0); N <= S[3]; C <= Cout (raw; for SUB C=1 means no borrow); V <= OVR; Sticky <= Sticky | OVR.
REQ-025 LOAD: ACC <= BR; Z <= (BR==0); N <= BR[3]; C and V hold; Sticky holds.
REQ-026 CLR: ACC <= 0; Flags <= {1,0,0,0}; Sticky <= 0.
REQ-027 ACC, Flags and Sticky SHALL change only at the EXEC->WB edge.
REQ-028 Start asserted in EXEC or WB SHALL be ignored (not queued); Start held high yields one operation every 3 cycles.
REQ-029 All arithmetic is 4-bit modulo 16; wrap-around is reported only via C, V and Sticky, never saturated.
REQ-030 Op and D changes after edge k SHALL NOT affect the operation in flight.

Reset
REQ-031 Resetn=0 SHALL immediately force state IDLE, ACC=0, BR=0, OpR=00, Flags=0000, Sticky=0, Busy=0, Done=0, AddSub=0.
REQ-032 Reset asserted mid-operation (EXEC or WB) aborts it: no ACC/Flags update and no Done pulse after release.
REQ-033 After Resetn deasserts, the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-034 Reset, LOAD D=0101 -> Busy high 2 cycles, Done pulse in cycle 3, ACC=0101, Flags=0000.
REQ-035 ACC=0111, ADD D=0001 -> ACC=1000, Flags Z=0 N=1 C=0 V=1, Sticky=1; AddSub=0 throughout.
REQ-036 ACC=0011, SUB D=0011 -> AddSub=1 in EXEC only, ACC=0000, Z=1 N=0 C=1 V=0.
REQ-037 ACC=0000, SUB D=0001 -> ACC=1111, Z=0 N=1 C=0 V=0; Sticky unchanged; then CLR -> ACC=0000, Flags=1000, Sticky=0.
REQ-038 Start held high with Op=ADD, D=0001 from ACC=0 -> ACC 1,2,3 on Done pulses spaced exactly 3 cycles apart.
REQ-039 ACC=0101, ADD D=0010, Resetn low during EXEC -> ACC=0000, Flags=0000, no Done after release.
